// File: rtl/mdr_mem_responder.sv
// mdr_mem_responder
//   Memory-side responder for the MAR/MDR operand interface. It holds the MAR
//   and MDR registers and a word-addressed RAM. It services multi-cycle
//   read/write requests and reports completion with a one-cycle R pulse.
//
//   Optional feature macro: MEM_BOUNDS_CHECK_EN
//     defined   : accesses with nonzero MAR[DATA_W-1:ADDR_W] still run the full
//                 latency, leave RAM and MDR untouched, and pulse ACV with R.
//     undefined : upper MAR bits are ignored (address wraps modulo DEPTH);
//                 ACV stays 0.
//
// Ports
//   CLK      in   rising-edge clock
//   RESET    in   asynchronous active-high reset
//   BUS_IN   in   datapath bus, source for MAR/MDR loads
//   LDMAR    in   load MAR from BUS_IN (accepted in IDLE only)
//   LDMDR    in   MIO_EN=0: load MDR from BUS_IN; MIO_EN=1: start memory access
//   MIO_EN   in   1 = memory access request, 0 = bus load of MDR
//   R_W      in   access type: 0 = read, 1 = write
//   GATEMDR  in   1: MDR_OUT = MDR, 0: MDR_OUT = 0
//   MDR_OUT  out  gated MDR value
//   MAR_OUT  out  current MAR
//   R        out  one-cycle pulse: access complete
//   BUSY     out  high while an access is in flight
//   ACV      out  one-cycle pulse: access violation
module mdr_mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] BUS_IN,
  input  logic              LDMAR,
  input  logic              LDMDR,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic              GATEMDR,
  output logic [DATA_W-1:0] MDR_OUT,
  output logic [DATA_W-1:0] MAR_OUT,
  output logic              R,
  output logic              BUSY,
  output logic              ACV
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  mar;
  logic [DATA_W-1:0]  mdr;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_p0;
  logic               rw_p0;
  logic               oob_p0;
  logic               oob_req;
  logic               ram_we;
  logic [DATA_W-1:0]  ram [DEPTH];

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob_req = |mar[DATA_W-1:ADDR_W];
`else
  assign oob_req = 1'b0;
`endif

  assign MDR_OUT = GATEMDR ? mdr : '0;
  assign MAR_OUT = mar;

  // RAM is never cleared; the write is gated by RESET so that a reset
  // arriving during DONE aborts the store.
  assign ram_we = (state == ST_DONE) && rw_p0 && !oob_p0 && !RESET;

  always_ff @(posedge CLK) begin
    if (ram_we) ram[addr_p0] <= mdr;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_IDLE;
      mar     <= '0;
      mdr     <= '0;
      cnt     <= '0;
      addr_p0 <= '0;
      rw_p0   <= 1'b0;
      oob_p0  <= 1'b0;
      R       <= 1'b0;
      BUSY    <= 1'b0;
      ACV     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          R   <= 1'b0;
          ACV <= 1'b0;
          if (LDMAR) mar <= BUS_IN;
          if (LDMDR) begin
            if (!MIO_EN) begin
              mdr <= BUS_IN;
            end else begin
              // Address is captured from the current (old) MAR even when
              // LDMAR updates MAR on this same edge.
              addr_p0 <= mar[ADDR_W-1:0];
              rw_p0   <= R_W;
              oob_p0  <= oob_req;
              cnt     <= CNT_W'(MEM_LATENCY - 1);
              state   <= ST_BUSY;
              BUSY    <= 1'b1;
            end
          end
        end
        // ---- access in flight ----
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            R     <= 1'b1;
            ACV   <= oob_p0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // ---- completion: read data lands in MDR, RAM write happens above ----
        ST_DONE: begin
          R     <= 1'b0;
          ACV   <= 1'b0;
          if (!rw_p0 && !oob_p0) mdr <= ram[addr_p0];
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          R     <= 1'b0;
          BUSY  <= 1'b0;
          ACV   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_mem_responder.sv
module tb_mdr_mem_responder;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;

  // main instance, MEM_LATENCY = 2
  logic [15:0] bus = '0;
  logic        ldmar = 0, ldmdr = 0, mio = 0, rw = 0, gate = 1;
  logic [15:0] mdr_out, mar_out;
  logic        r, busy, acv;

  // latency-1 and latency-4 instances share these inputs, separate LDMDR
  logic [15:0] bus2 = '0;
  logic        ldmar2 = 0, ldmdr_a = 0, ldmdr_b = 0, mio2 = 0, rw2 = 0, gate2 = 1;
  logic [15:0] mdr_out1, mar_out1, mdr_out4, mar_out4;
  logic        r1, busy1, acv1, r4, busy4, acv4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdr_mem_responder #(.DATA_W(16), .ADDR_W(8), .MEM_LATENCY(2)) dut (
    .CLK(clk), .RESET(RESET), .BUS_IN(bus), .LDMAR(ldmar), .LDMDR(ldmdr),
    .MIO_EN(mio), .R_W(rw), .GATEMDR(gate), .MDR_OUT(mdr_out),
    .MAR_OUT(mar_out), .R(r), .BUSY(busy), .ACV(acv));

  mdr_mem_responder #(.DATA_W(16), .ADDR_W(8), .MEM_LATENCY(1)) dut1 (
    .CLK(clk), .RESET(RESET), .BUS_IN(bus2), .LDMAR(ldmar2), .LDMDR(ldmdr_a),
    .MIO_EN(mio2), .R_W(rw2), .GATEMDR(gate2), .MDR_OUT(mdr_out1),
    .MAR_OUT(mar_out1), .R(r1), .BUSY(busy1), .ACV(acv1));

  mdr_mem_responder #(.DATA_W(16), .ADDR_W(8), .MEM_LATENCY(4)) dut4 (
    .CLK(clk), .RESET(RESET), .BUS_IN(bus2), .LDMAR(ldmar2), .LDMDR(ldmdr_b),
    .MIO_EN(mio2), .R_W(rw2), .GATEMDR(gate2), .MDR_OUT(mdr_out4),
    .MAR_OUT(mar_out4), .R(r4), .BUSY(busy4), .ACV(acv4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic r_of(input int sel);
    return (sel == 0) ? r : (sel == 1) ? r1 : r4;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy : (sel == 1) ? busy1 : busy4;
  endfunction

  function automatic logic acv_of(input int sel);
    return (sel == 0) ? acv : (sel == 1) ? acv1 : acv4;
  endfunction

  // Issue a request (any LDMAR the caller set up rides along on the accept
  // edge), then measure edges until R, and step into the following IDLE cycle.
  task automatic access(input int sel, input logic wr, input int lat,
                        input string tag, input logic acv_exp);
    int n;
    if (sel == 0) begin
      mio = 1; rw = wr; ldmdr = 1;
    end else begin
      mio2 = 1; rw2 = wr;
      if (sel == 1) ldmdr_a = 1; else ldmdr_b = 1;
    end
    tick;
    ldmdr = 0; ldmdr_a = 0; ldmdr_b = 0; ldmar = 0; ldmar2 = 0; mio = 0; mio2 = 0;
    chk({tag, "_busy"}, busy_of(sel), 1);
    n = 0;
    while (n < 20) begin
      tick;
      n++;
      if (r_of(sel)) break;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_acv"}, acv_of(sel), acv_exp);
    tick;
    chk({tag, "_rclr"}, r_of(sel), 0);
  endtask

  task automatic load_mar(input logic [15:0] v);
    bus = v; ldmar = 1; tick; ldmar = 0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    bus = v; mio = 0; ldmdr = 1; tick; ldmdr = 0;
  endtask

  task automatic load2(input int sel, input logic [15:0] a, input logic [15:0] d);
    bus2 = a; ldmar2 = 1; tick; ldmar2 = 0;
    bus2 = d; mio2 = 0;
    if (sel == 1) ldmdr_a = 1; else ldmdr_b = 1;
    tick;
    ldmdr_a = 0; ldmdr_b = 0;
  endtask

  initial begin
    logic acv_oob;
`ifdef MEM_BOUNDS_CHECK_EN
    acv_oob = 1'b1;
`else
    acv_oob = 1'b0;
`endif

    // ---- reset state ----
    tick; tick;
    chk("rst_mar", mar_out, 16'h0000);
    chk("rst_mdr", mdr_out, 16'h0000);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acv", acv, 0);
    RESET = 0;
    tick;

    // ---- write then read at 0x0012 ----
    load_mar(16'h0012);
    chk("t2_mar", mar_out, 16'h0012);
    load_mdr(16'hBEEF);
    chk("t2_mdr", mdr_out, 16'hBEEF);
    access(0, 1, 2, "t2_wr", 0);
    load_mdr(16'h0000);
    chk("t2_mdr_clr", mdr_out, 16'h0000);
    access(0, 0, 2, "t2_rd", 0);
    chk("t2_rd_data", mdr_out, 16'hBEEF);
    gate = 0; #1;
    chk("t2_gate_off", mdr_out, 16'h0000);
    gate = 1; #1;

    // ---- busy lockout ----
    load_mdr(16'h0000);
    mio = 1; rw = 0; ldmdr = 1;
    tick;
    mio = 0; ldmdr = 0;
    bus = 16'h0034; ldmar = 1;
    tick;
    chk("t3_mar_held", mar_out, 16'h0012);
    chk("t3_busy", busy, 1);
    ldmar = 0;
    tick;
    chk("t3_r", r, 1);
    tick;
    chk("t3_data", mdr_out, 16'hBEEF);
    chk("t3_mar_after", mar_out, 16'h0012);

    // ---- simultaneous LDMAR + access uses old MAR ----
    bus = 16'h0005; ldmar = 1; mio = 0; ldmdr = 1;
    tick;
    ldmar = 0; ldmdr = 0;
    chk("t4_mar5", mar_out, 16'h0005);
    chk("t4_mdr0505", mdr_out, 16'h0005);
    load_mdr(16'h0505);
    access(0, 1, 2, "t4_wr5", 0);
    load_mar(16'h0012);
    load_mdr(16'h0000);
    bus = 16'h0005; ldmar = 1;
    access(0, 0, 2, "t4_rd", 0);
    chk("t4_mar_new", mar_out, 16'h0005);
    chk("t4_old_addr_data", mdr_out, 16'hBEEF);

    // ---- wrap / bounds ----
    load_mar(16'h0003);
    load_mdr(16'h3333);
    access(0, 1, 2, "t5_wr3", 0);
    load_mar(16'h0103);
    load_mdr(16'hA5A5);
    access(0, 1, 2, "t5_wr103", acv_oob);
    load_mar(16'h0003);
    load_mdr(16'h0000);
    access(0, 0, 2, "t5_rd3", 0);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("t5_ram3", mdr_out, 16'h3333);
`else
    chk("t5_ram3", mdr_out, 16'hA5A5);
`endif

    // ---- reset mid-access ----
    load_mar(16'h0012);
    load_mdr(16'h7777);
    mio = 1; rw = 1; ldmdr = 1;
    tick;
    mio = 0; ldmdr = 0;
    tick;
    #2 RESET = 1;
    #1;
    chk("t1_mar", mar_out, 16'h0000);
    chk("t1_mdr", mdr_out, 16'h0000);
    chk("t1_r", r, 0);
    chk("t1_busy", busy, 0);
    tick;
    RESET = 0;
    tick;
    chk("t1_r_after", r, 0);
    load_mar(16'h0012);
    access(0, 0, 2, "t1_rd", 0);
    chk("t1_ram_intact", mdr_out, 16'hBEEF);

    // ---- latency 1: writes, then back-to-back reads at 0x0000, 0x00FF ----
    load2(1, 16'h0000, 16'h1111);
    access(1, 1, 1, "l1_wr0", 0);
    load2(1, 16'h00FF, 16'h2222);
    access(1, 1, 1, "l1_wrff", 0);
    bus2 = 16'h0000; ldmar2 = 1; tick; ldmar2 = 0;
    bus2 = 16'h00FF; ldmar2 = 1;
    access(1, 0, 1, "l1_rd0", 0);
    chk("l1_data0", mdr_out1, 16'h1111);
    access(1, 0, 1, "l1_rdff", 0);
    chk("l1_dataff", mdr_out1, 16'h2222);

    // ---- latency 4 ----
    load2(4, 16'h0000, 16'h4444);
    access(4, 1, 4, "l4_wr0", 0);
    load2(4, 16'h00FF, 16'h8888);
    access(4, 1, 4, "l4_wrff", 0);
    bus2 = 16'h0000; ldmar2 = 1; tick; ldmar2 = 0;
    bus2 = 16'h00FF; ldmar2 = 1;
    access(4, 0, 4, "l4_rd0", 0);
    chk("l4_data0", mdr_out4, 16'h4444);
    access(4, 0, 4, "l4_rdff", 0);
    chk("l4_dataff", mdr_out4, 16'h8888);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
